// File: rtl/sha256_compress_engine.sv
// sha256_compress_engine
// Iterative SHA-256 compression core. It latches the chaining value, the expanded message
// schedule W0..W63 and the round constants on an accepted start. It then runs the
// compression rounds and adds the chaining value to produce a digest or midstate.
// Optional build macro: SHA256_DOUBLE_ROUND_EN. When it is defined, two chained rounds
// run per clock.
module sha256_compress_engine #(
    parameter int ROUNDS    = 64,
    parameter bit ADD_CHAIN = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [255:0]  hashIn,
    input  logic [2047:0] schedule,
    input  logic [2047:0] constantValues,
    output logic          busy,
    output logic          done,
    output logic [255:0]  hashOut
);

`ifdef SHA256_DOUBLE_ROUND_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    // Counter value of the last ROUND edge; the counter is cleared on accept, so it never wraps.
    localparam logic [6:0] LAST_T = 7'(ROUNDS - STEP);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    state_t         state_reg, state_next;
    logic [6:0]     t_reg;
    logic [255:0]   vars_reg;       // a..h, a at [255:224]
    logic [255:0]   hash_in_reg;
    logic [2047:0]  w_reg;          // current Wt always sits in the top word
    logic [2047:0]  k_reg;          // current Kt always sits in the top word
    logic           done_reg;
    logic [255:0]   hash_out_reg;

    logic           load;
    logic           advance;
    logic           finish;
    logic [255:0]   round_one;
    logic [255:0]   round_step;
    logic [255:0]   final_hash;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // One SHA-256 round on packed working variables a..h.
    function automatic logic [255:0] sha_round(input logic [255:0] v, input logic [31:0] k,
                                               input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = v;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    assign round_one = sha_round(vars_reg, k_reg[2047:2016], w_reg[2047:2016]);
`ifdef SHA256_DOUBLE_ROUND_EN
    assign round_step = sha_round(round_one, k_reg[2015:1984], w_reg[2015:1984]);
`else
    assign round_step = round_one;
`endif

    // Per-word chaining addition (or raw working variables when chaining is disabled).
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_final
            if (ADD_CHAIN) begin : g_add
                assign final_hash[255 - 32*gi -: 32] =
                    hash_in_reg[255 - 32*gi -: 32] + vars_reg[255 - 32*gi -: 32];
            end else begin : g_raw
                assign final_hash[255 - 32*gi -: 32] = vars_reg[255 - 32*gi -: 32];
            end
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic: IDLE -> ROUND -> FINAL -> IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ROUND;
            ROUND:   if (t_reg == LAST_T) state_next = FINAL;
            FINAL:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / control decode; start is only honoured in IDLE.
    always_comb begin
        load    = (state_reg == IDLE) && start;
        advance = (state_reg == ROUND);
        finish  = (state_reg == FINAL);
        busy    = (state_reg != IDLE);
    end

    // Datapath: latch inputs on accept, advance rounds, publish the result on FINAL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_reg        <= '0;
            vars_reg     <= '0;
            hash_in_reg  <= '0;
            w_reg        <= '0;
            k_reg        <= '0;
            done_reg     <= 1'b0;
            hash_out_reg <= '0;
        end else begin
            done_reg <= finish;
            if (load) begin
                hash_in_reg <= hashIn;
                vars_reg    <= hashIn;
                w_reg       <= schedule;
                k_reg       <= constantValues;
                t_reg       <= '0;
            end else if (advance) begin
                vars_reg <= round_step;
                w_reg    <= w_reg << (32 * STEP);
                k_reg    <= k_reg << (32 * STEP);
                t_reg    <= t_reg + 7'(STEP);
            end
            if (finish) hash_out_reg <= final_hash;
        end
    end

    assign done    = done_reg;
    assign hashOut = hash_out_reg;

endmodule
